l1_pool_rd_ctrl: RTL and testbench

//  Read side of the layer-1 pool line buffers. Line 0 and line 1 are written by the L1 row-select controller.
//  On each "line pair ready" pulse, reads both lines in lock-step, 2x2 max-pools them and streams the result.

---
 rtl/l1_pool_pkg.sv | 10 +
 rtl/pool_max2.sv | 11 +
 rtl/l1_pool_rd_ctrl.sv | 76 +++++++
 tb/tb_l1_pool_rd_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/l1_pool_pkg.sv
// l1_pool_pkg: shared sizes, FSM encoding and max helper for the layer-1 pool read side
package l1_pool_pkg;
  localparam int DW = 8;
  localparam int LINE_LEN = 24;
  localparam int ROW_PAIRS = 26;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} pool_state_t;
  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sgn);
    return (sgn ? ($signed(a) > $signed(b)) : (a > b)) ? a : b;
  endfunction
endpackage

// File: rtl/pool_max2.sv
// pool_max2: combinational max of two samples, signed or unsigned compare
module pool_max2 #(
  parameter int DW = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);
  always_comb y = (SIGNED ? ($signed(a) > $signed(b)) : (a > b)) ? a : b;
endmodule

// File: rtl/l1_pool_rd_ctrl.sv
// l1_pool_rd_ctrl: reads both L1 pool lines in lock-step, 2x2 max-pools them and streams the result
module l1_pool_rd_ctrl
  import l1_pool_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          PoolEn_i,
  input  logic          vbit_i,
  output logic [4:0]    PoolLineRdAddr_o,
  output logic          PoolLineRe_o,
  input  logic [DW-1:0] PoolLine0Data_i,
  input  logic [DW-1:0] PoolLine1Data_i,
  output logic [DW-1:0] PoolData_o,
  output logic          PoolValid_o,
  input  logic          PoolReady_i,
  output logic          PoolRowLast_o,
  output logic          PoolFrameLast_o,
  output logic          Busy_o,
  output logic          Overrun_o
);
  pool_state_t state, state_nxt;
  logic [4:0] rd_cnt;
  logic [3:0] col_cnt;
  logic [4:0] pair_cnt;
  logic [DW-1:0] hold_reg, v_max, h_max;
  logic pending, rd_vld, rd_odd, accept, row_last, rd_last, go_pend;
  pool_max2 #(.DW(DW), .SIGNED(SIGNED)) u_vmax (.a(PoolLine0Data_i), .b(PoolLine1Data_i), .y(v_max));
  pool_max2 #(.DW(DW), .SIGNED(SIGNED)) u_hmax (.a(hold_reg), .b(v_max), .y(h_max));
  assign accept = PoolValid_o & PoolReady_i;
  assign row_last = col_cnt == 4'(LINE_LEN / 2 - 1);
  assign rd_last = rd_cnt == 5'(LINE_LEN - 1);
  assign PoolRowLast_o = PoolValid_o & row_last;
  assign PoolFrameLast_o = PoolRowLast_o & (pair_cnt == 5'(ROW_PAIRS - 1));
  assign PoolLineRdAddr_o = rd_cnt;
  assign Busy_o = state != IDLE;
  always_comb begin
    state_nxt = state;
    PoolLineRe_o = 1'b0;
    go_pend = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = (vbit_i | pending) ? READ : IDLE;
        go_pend = pending;
      end
      READ: begin
        PoolLineRe_o = PoolEn_i & (~rd_cnt[0] | ~PoolValid_o | PoolReady_i);
        state_nxt = (PoolLineRe_o & rd_last) ? DRAIN : READ;
      end
      DRAIN: begin
        state_nxt = pending ? READ : (accept & PoolRowLast_o) ? IDLE : DRAIN;
        go_pend = pending;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= PoolEn_i ? state_nxt : IDLE;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) {rd_cnt, col_cnt, pair_cnt, hold_reg, PoolData_o, PoolValid_o, pending, Overrun_o, rd_vld, rd_odd} <= '0;
    else if (!PoolEn_i) {rd_cnt, col_cnt, pair_cnt, hold_reg, PoolData_o, PoolValid_o, pending, Overrun_o, rd_vld, rd_odd} <= '0;
    else begin
      rd_vld <= PoolLineRe_o;
      rd_odd <= rd_cnt[0];
      if (PoolLineRe_o) rd_cnt <= rd_last ? '0 : rd_cnt + 5'd1;
      if (rd_vld & ~rd_odd) hold_reg <= v_max;
      if (rd_vld & rd_odd) PoolData_o <= h_max;
      PoolValid_o <= (rd_vld & rd_odd) | (PoolValid_o & ~PoolReady_i);
      if (accept) col_cnt <= row_last ? '0 : col_cnt + 4'd1;
      if (accept & row_last) pair_cnt <= (pair_cnt == 5'(ROW_PAIRS - 1)) ? '0 : pair_cnt + 5'd1;
      pending <= ~go_pend & (pending | (vbit_i & Busy_o));
      Overrun_o <= Overrun_o | (vbit_i & pending);
    end
endmodule

// File: tb/tb_l1_pool_rd_ctrl.sv
// tb_l1_pool_rd_ctrl: randomized self-checking bench for l1_pool_rd_ctrl against a scoreboard model
module tb_l1_pool_rd_ctrl;
  import l1_pool_pkg::*;
  localparam int NS = LINE_LEN / 2;
  typedef struct packed {logic [DW-1:0] ds; logic [DW-1:0] du; logic rl; logic fl;} exp_t;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, vbit = 1'b0, ready = 1'b1;
  logic [4:0] addr_s, addr_u;
  logic re_s, re_u, valid_s, valid_u, rl_s, rl_u, fl_s, fl_u, busy_s, busy_u, ov_s, ov_u;
  logic [DW-1:0] d0s, d1s, d0u, d1u, data_s, data_u;
  logic [DW-1:0] l0 [LINE_LEN];
  logic [DW-1:0] l1 [LINE_LEN];
  exp_t q[$];
  exp_t me;
  int n_cmp = 0, n_bad = 0, pair_idx = 0, fl_seen = 0, fl0 = 0;
  int fv, lv, dn, gaps, ovf;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (re_s) begin d0s <= l0[addr_s]; d1s <= l1[addr_s]; end
    if (re_u) begin d0u <= l0[addr_u]; d1u <= l1[addr_u]; end
  end
  l1_pool_rd_ctrl #(.SIGNED(1'b1)) dut_s (.clk(clk), .rstn(rstn), .PoolEn_i(en), .vbit_i(vbit),
    .PoolLineRdAddr_o(addr_s), .PoolLineRe_o(re_s), .PoolLine0Data_i(d0s), .PoolLine1Data_i(d1s),
    .PoolData_o(data_s), .PoolValid_o(valid_s), .PoolReady_i(ready), .PoolRowLast_o(rl_s),
    .PoolFrameLast_o(fl_s), .Busy_o(busy_s), .Overrun_o(ov_s));
  l1_pool_rd_ctrl #(.SIGNED(1'b0)) dut_u (.clk(clk), .rstn(rstn), .PoolEn_i(en), .vbit_i(vbit),
    .PoolLineRdAddr_o(addr_u), .PoolLineRe_o(re_u), .PoolLine0Data_i(d0u), .PoolLine1Data_i(d1u),
    .PoolData_o(data_u), .PoolValid_o(valid_u), .PoolReady_i(ready), .PoolRowLast_o(rl_u),
    .PoolFrameLast_o(fl_u), .Busy_o(busy_u), .Overrun_o(ov_u));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int sx(input logic [DW-1:0] v);
    return v[DW-1] ? int'(v) - (1 << DW) : int'(v);
  endfunction
  task automatic push_pair();
    exp_t e;
    int ms, mu;
    logic [DW-1:0] v;
    for (int c = 0; c < NS; c++) begin
      ms = -(1 << 30);
      mu = -1;
      for (int j = 0; j < 4; j++) begin
        v = (j < 2) ? l0[2*c + j] : l1[2*c + j - 2];
        ms = (sx(v) > ms) ? sx(v) : ms;
        mu = (int'(v) > mu) ? int'(v) : mu;
      end
      e.ds = DW'(ms);
      e.du = DW'(mu);
      e.rl = (c == NS - 1);
      e.fl = e.rl && (pair_idx == ROW_PAIRS - 1);
      q.push_back(e);
    end
    pair_idx = (pair_idx + 1) % ROW_PAIRS;
  endtask
  task automatic fill_ramp();
    for (int i = 0; i < LINE_LEN; i++) begin l0[i] = DW'(i); l1[i] = DW'(LINE_LEN - 1 - i); end
  endtask
  task automatic fill_const(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int i = 0; i < LINE_LEN; i++) begin l0[i] = a; l1[i] = b; end
  endtask
  task automatic fill_rand();
    for (int i = 0; i < LINE_LEN; i++) begin l0[i] = DW'($urandom); l1[i] = DW'($urandom); end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start();
    step();
    vbit = 1'b1;
    ready = 1'b1;
  endtask
  task automatic run(input int p2, input int p3, input int rlo, input int rhi, input bit rnd, input int lim);
    fv = -1; lv = -1; dn = -1; gaps = 0; ovf = -1;
    for (int k = 1; k <= lim; k++) begin
      step();
      vbit = (k == p2) || (k == p3);
      ready = rnd ? ($urandom_range(0, 3) != 0) : !(k >= rlo && k <= rhi);
      @(negedge clk);
      if (valid_s) begin if (fv < 0) fv = k; lv = k; end
      if (ov_s && ovf < 0) ovf = k;
      if (!busy_s && !vbit && q.size() == 0) begin dn = k; break; end
      if (!busy_s && q.size() != 0) gaps++;
    end
    vbit = 1'b0;
    ready = 1'b1;
  endtask
  task automatic disable_once();
    step();
    en = 1'b0;
    q.delete();
    pair_idx = 0;
    step();
    chk("clr_valid", valid_s, 0);
    chk("clr_busy", busy_s, 0);
    chk("clr_overrun", ov_s, 0);
    chk("clr_addr", addr_s, 0);
    en = 1'b1;
  endtask
  always @(negedge clk)
    if (rstn && en && valid_s && ready) begin
      chk("sample_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("data_signed", data_s, me.ds);
        chk("data_unsigned", data_u, me.du);
        chk("valid_unsigned", valid_u, 1);
        chk("row_last", rl_s, me.rl);
        chk("row_last_u", rl_u, me.rl);
        chk("frame_last", fl_s, me.fl);
        chk("frame_last_u", fl_u, me.fl);
        if (fl_s) fl_seen++;
      end
    end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_s, 0);
    chk("rst_data", data_s, 0);
    chk("rst_re", re_s, 0);
    chk("rst_addr", addr_s, 0);
    chk("rst_rowlast", rl_s, 0);
    chk("rst_framelast", fl_s, 0);
    chk("rst_busy", busy_s, 0);
    chk("rst_overrun", ov_s, 0);
    chk("rst_busy_u", busy_u, 0);
    chk("rst_overrun_u", ov_u, 0);
    rstn = 1'b1;
    step();
    en = 1'b1;
    fill_ramp(); push_pair(); start(); run(-1, -1, -1, -1, 1'b0, 100);
    chk("t1_first_valid", fv, 4);
    chk("t1_last_valid", lv, 26);
    chk("t1_idle_cycle", dn, 27);
    chk("t1_gaps", gaps, 0);
    chk("t1_overrun", ovf, -1);
    fill_ramp(); push_pair(); start(); run(-1, -1, 5, 14, 1'b0, 200);
    chk("t2_done", dn > 0, 1);
    chk("t2_first_valid", fv, 4);
    chk("t2_gaps", gaps, 0);
    fill_ramp(); push_pair(); push_pair(); start(); run(5, 6, -1, -1, 1'b0, 200);
    chk("t3_first_valid", fv, 4);
    chk("t3_last_valid", lv, 51);
    chk("t3_idle_cycle", dn, 52);
    chk("t3_gaps", gaps, 0);
    chk("t3_overrun_cycle", ovf, 7);
    chk("t3_overrun_sticky", ov_s, 1);
    disable_once();
    fill_const(8'h80, 8'h7F); push_pair(); start(); run(-1, -1, -1, -1, 1'b1, 300);
    chk("t4a_done", dn > 0, 1);
    fill_const(8'h7F, 8'h80); push_pair(); start(); run(-1, -1, -1, -1, 1'b1, 300);
    chk("t4b_done", dn > 0, 1);
    for (int p = 0; p < 6; p++) begin
      int extra;
      extra = int'($urandom_range(0, 1));
      fill_rand(); push_pair();
      if (extra != 0) push_pair();
      start(); run(extra != 0 ? int'($urandom_range(2, 20)) : -1, -1, -1, -1, 1'b1, 400);
      chk("rnd_done", dn > 0, 1);
      chk("rnd_overrun", ovf, -1);
    end
    disable_once();
    fl0 = fl_seen;
    for (int p = 0; p < ROW_PAIRS; p++) begin
      fill_rand(); push_pair(); start(); run(-1, -1, -1, -1, 1'b1, 300);
      chk("t5_done", dn > 0, 1);
    end
    chk("t5_frame_last_count", fl_seen - fl0, 1);
    fill_rand(); push_pair(); start(); run(-1, -1, -1, -1, 1'b0, 100);
    chk("t5_wrap_done", dn, 27);
    chk("t5_wrap_no_framelast", fl_seen - fl0, 1);
    fill_rand(); push_pair(); start(); run(-1, -1, -1, -1, 1'b0, 9);
    step();
    en = 1'b0;
    q.delete();
    pair_idx = 0;
    step();
    chk("t6_abort_valid", valid_s, 0);
    chk("t6_abort_busy", busy_s, 0);
    chk("t6_abort_addr", addr_s, 0);
    en = 1'b1;
    fill_rand(); push_pair(); start(); run(-1, -1, -1, -1, 1'b0, 100);
    chk("t6_restart_first", fv, 4);
    chk("t6_restart_done", dn, 27);
    fill_rand(); push_pair(); start(); run(-1, -1, -1, -1, 1'b0, 9);
    step();
    rstn = 1'b0;
    q.delete();
    pair_idx = 0;
    #1;
    chk("t6_rst_valid", valid_s, 0);
    chk("t6_rst_busy", busy_s, 0);
    chk("t6_rst_re", re_s, 0);
    step();
    rstn = 1'b1;
    fill_rand(); push_pair(); start(); run(-1, -1, -1, -1, 1'b0, 100);
    chk("t6_rst_restart_first", fv, 4);
    chk("t6_rst_restart_done", dn, 27);
    chk("end_queue_empty", q.size(), 0);
    chk("end_overrun", ov_s, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
